ld_st_sl_writer: RTL and testbench

- Serial writer for the load/store serial register chain: accepts a parallel WIDTH-bit word on a start/ready handshake.
- Shifts the word out one bit per clock on sl_data while asserting the load strobe l_s; then holds l_s low for a store interval and pulses done.
- Drives the sl_in / l_s inputs of the serial-load register cells. It is the transmit end of the same sl_in/l_s interface.

---
 rtl/ld_st_sl_writer_pkg.sv | 15 +
 rtl/ld_st_bit_cnt.sv | 33 +++
 rtl/ld_st_sl_writer.sv | 145 ++++++++++++++
 tb/tb_ld_st_sl_writer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ld_st_sl_writer_pkg.sv
// Shared definitions for the load/store serial chain: state encodings and
// default geometry so the writer and the receiver cells agree.
package ld_st_sl_writer_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_HOLD   = 2;
    localparam int HOLD_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

endpackage

// File: rtl/ld_st_bit_cnt.sv
// Loadable up-counter with async active-low clear, sync clear and a
// terminal-count flag that is high while the count equals LAST.
module ld_st_bit_cnt #(
    parameter int W    = 4,
    parameter int LAST = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         sclr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic         tc
);

    logic [W-1:0] count_reg;

    // Sync clear beats load, load beats increment.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_reg <= '0;
        end else if (sclr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (inc) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign tc = (count_reg == W'(LAST));

endmodule

// File: rtl/ld_st_sl_writer.sv
// Serial writer for the load/store register chain: shifts a parallel word out
// under l_s, then holds l_s low for a store interval and pulses done.
module ld_st_sl_writer
    import ld_st_sl_writer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MSB_FIRST = 1,
    parameter int HOLD      = DEF_HOLD
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    input  logic             abort,
    output logic             ready,
    output logic             sl_data,
    output logic             l_s,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH + 1);

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] data_ord;
    logic             ready_reg;
    logic             sl_data_reg;
    logic             l_s_reg;
    logic             done_reg;

    logic bit_tc;
    logic bit_load;
    logic bit_inc;
    logic bit_sclr;
    logic hold_tc;
    logic hold_load;
    logic hold_inc;
    logic hold_sclr;

    // Reorder the word so the shifter always walks from the top bit down.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
            if (MSB_FIRST != 0) begin : g_msb
                assign data_ord[gi] = data_in[gi];
            end else begin : g_lsb
                assign data_ord[gi] = data_in[WIDTH-1-gi];
            end
        end
    endgenerate

    assign bit_load  = (state_reg == ST_IDLE) && start;
    assign bit_inc   = (state_reg == ST_SHIFT) && !bit_tc && !abort;
    assign bit_sclr  = (state_reg == ST_SHIFT) && (abort || bit_tc);
    assign hold_load = (state_reg == ST_SHIFT) && bit_tc && !abort;
    assign hold_inc  = (state_reg == ST_HOLD) && !hold_tc && !abort;
    assign hold_sclr = (state_reg == ST_HOLD) && (abort || hold_tc);

    ld_st_bit_cnt #(
        .W    (BCW),
        .LAST (WIDTH)
    ) u_bit_cnt (
        .clk      (clk),
        .clr      (clr),
        .sclr     (bit_sclr),
        .load     (bit_load),
        .load_val (BCW'(1)),
        .inc      (bit_inc),
        .tc       (bit_tc)
    );

    ld_st_bit_cnt #(
        .W    (HOLD_CNT_W),
        .LAST (HOLD)
    ) u_hold_cnt (
        .clk      (clk),
        .clr      (clr),
        .sclr     (hold_sclr),
        .load     (hold_load),
        .load_val (HOLD_CNT_W'(1)),
        .inc      (hold_inc),
        .tc       (hold_tc)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            ready_reg   <= 1'b1;
            sl_data_reg <= 1'b0;
            l_s_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // abort is meaningless here, so start always wins.
                    if (start) begin
                        shift_reg   <= data_ord << 1;
                        sl_data_reg <= data_ord[WIDTH-1];
                        l_s_reg     <= 1'b1;
                        ready_reg   <= 1'b0;
                        state_reg   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        l_s_reg     <= 1'b0;
                        sl_data_reg <= 1'b0;
                        ready_reg   <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end else if (bit_tc) begin
                        l_s_reg     <= 1'b0;
                        sl_data_reg <= 1'b0;
                        state_reg   <= ST_HOLD;
                    end else begin
                        sl_data_reg <= shift_reg[WIDTH-1];
                        shift_reg   <= shift_reg << 1;
                    end
                end
                ST_HOLD: begin
                    if (abort) begin
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else if (hold_tc) begin
                        done_reg  <= 1'b1;
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    l_s_reg     <= 1'b0;
                    sl_data_reg <= 1'b0;
                    ready_reg   <= 1'b1;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready   = ready_reg;
    assign sl_data = sl_data_reg;
    assign l_s     = l_s_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_ld_st_sl_writer.sv
// Directed bench for ld_st_sl_writer: one MSB-first and one LSB-first instance
// sharing clock and reset, with a receiver model built from observed l_s/sl_data.
module tb_ld_st_sl_writer;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] data_a = '0;
    logic       start_a = 1'b0;
    logic       abort_a = 1'b0;
    logic       ready_a, sl_a, ls_a, done_a;
    logic [7:0] data_b = '0;
    logic       start_b = 1'b0;
    logic       abort_b = 1'b0;
    logic       ready_b, sl_b, ls_b, done_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ld_st_sl_writer #(.WIDTH(8), .MSB_FIRST(1), .HOLD(2)) dut (
        .clk(clk), .clr(clr), .data_in(data_a), .start(start_a), .abort(abort_a),
        .ready(ready_a), .sl_data(sl_a), .l_s(ls_a), .done(done_a)
    );

    ld_st_sl_writer #(.WIDTH(8), .MSB_FIRST(0), .HOLD(2)) dut_lsb (
        .clk(clk), .clr(clr), .data_in(data_b), .start(start_b), .abort(abort_b),
        .ready(ready_b), .sl_data(sl_b), .l_s(ls_b), .done(done_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick();
        tick();
        n_cmp++;
        if ({ready_a, ls_a, sl_a, done_a} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_a: got rdy/ls/sl/done=%b need 1000", {ready_a, ls_a, sl_a, done_a});
        end
        n_cmp++;
        if ({ready_b, ls_b, sl_b, done_b} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_b: got rdy/ls/sl/done=%b need 1000", {ready_b, ls_b, sl_b, done_b});
        end
        clr = 1'b1;
        tick();
        $display("xfer reset released");
    endtask

    task automatic test_msb_a5;
        logic [7:0] w;
        logic [7:0] rx;
        w = 8'hA5;
        rx = '0;
        data_a = w;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        data_a = 8'h00;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (ls_a !== 1'b1 || sl_a !== w[7-k] || ready_a !== 1'b0) begin
                n_bad++;
                $display("FAIL msb_bit%0d: got ls=%b sl=%b rdy=%b need ls=1 sl=%b rdy=0", k, ls_a, sl_a, ready_a, w[7-k]);
            end
            if (ls_a === 1'b1) rx = {rx[6:0], sl_a};
            tick();
        end
        for (int h = 0; h < 2; h++) begin
            n_cmp++;
            if ({ls_a, sl_a, done_a} !== 3'b000) begin
                n_bad++;
                $display("FAIL msb_hold%0d: got ls/sl/done=%b need 000", h, {ls_a, sl_a, done_a});
            end
            tick();
        end
        n_cmp++;
        if (done_a !== 1'b1 || ready_a !== 1'b1 || ls_a !== 1'b0) begin
            n_bad++;
            $display("FAIL msb_done: got done=%b rdy=%b ls=%b need 1 1 0", done_a, ready_a, ls_a);
        end
        tick();
        n_cmp++;
        if (done_a !== 1'b0) begin
            n_bad++;
            $display("FAIL msb_done_pulse: got done=%b need 0", done_a);
        end
        n_cmp++;
        if (rx !== 8'hA5) begin
            n_bad++;
            $display("FAIL msb_rx: got %h need a5", rx);
        end
        $display("xfer msb data=a5 rx=%h", rx);
    endtask

    task automatic test_lsb_01;
        logic [7:0] w;
        logic [7:0] rx;
        w = 8'h01;
        rx = '0;
        data_b = w;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (ls_b !== 1'b1 || sl_b !== w[k]) begin
                n_bad++;
                $display("FAIL lsb_bit%0d: got ls=%b sl=%b need ls=1 sl=%b", k, ls_b, sl_b, w[k]);
            end
            if (ls_b === 1'b1) rx = {sl_b, rx[7:1]};
            tick();
        end
        for (int h = 0; h < 2; h++) begin
            if (ls_b === 1'b1) rx = {sl_b, rx[7:1]};
            tick();
        end
        n_cmp++;
        if (done_b !== 1'b1 || rx !== 8'h01) begin
            n_bad++;
            $display("FAIL lsb_done_rx: got done=%b rx=%h need done=1 rx=01", done_b, rx);
        end
        tick();
        $display("xfer lsb data=01 rx=%h", rx);
    endtask

    task automatic test_back_to_back;
        int low;
        int guard;
        data_a = 8'hFF;
        start_a = 1'b1;
        tick();
        data_a = 8'h00;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (ls_a !== 1'b1 || sl_a !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_ff_bit%0d: got ls=%b sl=%b need 1 1", k, ls_a, sl_a);
            end
            tick();
        end
        low = 0;
        guard = 0;
        while (done_a !== 1'b1 && guard < 20) begin
            if (ls_a === 1'b0) low++;
            guard++;
            tick();
        end
        n_cmp++;
        if (done_a !== 1'b1 || ready_a !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_first_done: got done=%b rdy=%b need 1 1", done_a, ready_a);
        end
        n_cmp++;
        if (low != 2) begin
            n_bad++;
            $display("FAIL b2b_store_cycles: got %0d need 2", low);
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (ls_a !== 1'b1 || sl_a !== 1'b0 || ready_a !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_00_bit%0d: got ls=%b sl=%b rdy=%b need 1 0 0", k, ls_a, sl_a, ready_a);
            end
            start_a = 1'b0;
            tick();
        end
        guard = 0;
        while (done_a !== 1'b1 && guard < 20) begin
            guard++;
            tick();
        end
        n_cmp++;
        if (done_a !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_second_done: got done=%b need 1 (timeout)", done_a);
        end
        tick();
        $display("xfer b2b ff then 00");
    endtask

    task automatic test_ignore_start;
        logic [7:0] w;
        int dones;
        int highs;
        w = 8'hA5;
        data_a = w;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (ls_a !== 1'b1 || sl_a !== w[7-k]) begin
                n_bad++;
                $display("FAIL ign_bit%0d: got ls=%b sl=%b need 1 %b", k, ls_a, sl_a, w[7-k]);
            end
            if (k == 2) begin
                data_a = 8'h3C;
                start_a = 1'b1;
            end else begin
                start_a = 1'b0;
            end
            tick();
        end
        dones = 0;
        highs = 0;
        for (int c = 0; c < 8; c++) begin
            if (done_a === 1'b1) dones++;
            if (ls_a === 1'b1) highs++;
            tick();
        end
        n_cmp++;
        if (dones != 1 || highs != 0) begin
            n_bad++;
            $display("FAIL ign_once: got dones=%0d ls_high=%0d need 1 0", dones, highs);
        end
        $display("xfer ignore start data=a5");
    endtask

    task automatic test_abort;
        logic [7:0] w;
        int dones;
        int highs;
        w = 8'hA5;
        data_a = w;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (ls_a !== 1'b1 || sl_a !== w[2]) begin
            n_bad++;
            $display("FAIL abort_pre: got ls=%b sl=%b need 1 %b", ls_a, sl_a, w[2]);
        end
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        n_cmp++;
        if ({ls_a, sl_a, ready_a, done_a} !== 4'b0010) begin
            n_bad++;
            $display("FAIL abort_shift: got ls/sl/rdy/done=%b need 0010", {ls_a, sl_a, ready_a, done_a});
        end
        dones = 0;
        highs = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_a === 1'b1) dones++;
            if (ls_a === 1'b1) highs++;
            tick();
        end
        n_cmp++;
        if (dones != 0 || highs != 0) begin
            n_bad++;
            $display("FAIL abort_quiet: got dones=%0d ls_high=%0d need 0 0", dones, highs);
        end
        data_a = w;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (9) tick();
        n_cmp++;
        if ({ls_a, done_a, ready_a} !== 3'b000) begin
            n_bad++;
            $display("FAIL abort_hold_pre: got ls/done/rdy=%b need 000", {ls_a, done_a, ready_a});
        end
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        n_cmp++;
        if (done_a !== 1'b0 || ready_a !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_last_hold: got done=%b rdy=%b need 0 1", done_a, ready_a);
        end
        tick();
        n_cmp++;
        if (done_a !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_last_hold_after: got done=%b need 0", done_a);
        end
        data_a = 8'hC3;
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        n_cmp++;
        if (ls_a !== 1'b1 || sl_a !== 1'b1 || ready_a !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_start_idle: got ls=%b sl=%b rdy=%b need 1 1 0", ls_a, sl_a, ready_a);
        end
        repeat (12) tick();
        n_cmp++;
        if (ready_a !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_start_finish: got rdy=%b need 1", ready_a);
        end
        $display("xfer abort scenarios");
    endtask

    task automatic test_reset_mid;
        data_a = 8'hA5;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (3) tick();
        #1;
        clr = 1'b0;
        #1;
        n_cmp++;
        if ({ls_a, sl_a, ready_a, done_a} !== 4'b0010) begin
            n_bad++;
            $display("FAIL reset_mid: got ls/sl/rdy/done=%b need 0010", {ls_a, sl_a, ready_a, done_a});
        end
        #1;
        clr = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if (ready_a !== 1'b1 || ls_a !== 1'b0 || done_a !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_mid_idle%0d: got rdy=%b ls=%b done=%b need 1 0 0", c, ready_a, ls_a, done_a);
            end
        end
        $display("xfer reset mid-shift");
    endtask

    initial begin
        test_reset();
        test_msb_a5();
        test_lsb_01();
        test_back_to_back();
        test_ignore_start();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
